// File: rtl/ghash_pkg.sv
// Shared definitions for the GHASH input framing path: block width, FSM
// encoding, length-block layout and the final-block keep mask.
package ghash_pkg;

  localparam int unsigned NB_BLOCK     = 128;
  localparam int unsigned NB_LEN_FIELD = 64;
  // Length block layout: len_aad at [127:64], len_ct at [63:0].
  localparam int unsigned LEN_AAD_LSB  = 64;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAad  = 2'd1,
    StCt   = 2'd2,
    StLen  = 2'd3
  } state_e;

  // Keep mask for the last block of a phase: byte 0 sits at the MSBs, so a
  // partial block of k bytes keeps its top 8k bits. k == 0 means full block.
  function automatic logic [NB_BLOCK-1:0] keep_mask(input logic [3:0] last_bytes);
    logic [NB_BLOCK-1:0] ones;
    ones = '1;
    if (last_bytes == 4'd0) return ones;
    return ~(ones >> {last_bytes, 3'b000});
  endfunction

  function automatic logic [NB_BLOCK-1:0] len_block(input logic [NB_LEN_FIELD-1:0] len_aad,
                                                    input logic [NB_LEN_FIELD-1:0] len_ct);
    logic [NB_BLOCK-1:0] blk;
    blk = '0;
    blk[LEN_AAD_LSB +: NB_LEN_FIELD] = len_aad;
    blk[0 +: NB_LEN_FIELD]           = len_ct;
    return blk;
  endfunction

endpackage

// File: rtl/ghash_pad_mask.sv
// Per-block masking over one bus word: blocks at or above i_n_blocks are
// zeroed and flagged as skipped; the highest live block is optionally padded.
module ghash_pad_mask
  import ghash_pkg::*;
#(
  parameter int unsigned N_BLOCKS      = 2,
  parameter int unsigned LOG2_N_BLOCKS = 1,
  parameter int unsigned NB_DATA       = N_BLOCKS * NB_BLOCK
) (
  input  logic [NB_DATA-1:0]       i_data_bus,
  input  logic [LOG2_N_BLOCKS:0]   i_n_blocks,
  input  logic                     i_pad_en,
  input  logic [3:0]               i_last_bytes,
  output logic [NB_DATA-1:0]       o_data_bus,
  output logic [N_BLOCKS-1:0]      o_skip_bus
);

  logic [NB_BLOCK-1:0] keep;
  logic [NB_BLOCK-1:0] blk;

  assign keep = keep_mask(i_last_bytes);

  // Pass live blocks, pad the last live one, zero and skip the rest.
  always_comb begin
    o_data_bus = '0;
    o_skip_bus = '0;
    blk        = '0;
    for (int b = 0; b < int'(N_BLOCKS); b++) begin
      if (b < int'(i_n_blocks)) begin
        blk = i_data_bus[b*NB_BLOCK +: NB_BLOCK];
        if (i_pad_en && (b == int'(i_n_blocks) - 1)) blk = blk & keep;
        o_data_bus[b*NB_BLOCK +: NB_BLOCK] = blk;
      end else begin
        o_skip_bus[b] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ghash_input_framer.sv
// Frames one AES-GCM message (AAD, then ciphertext, then the length block)
// into N-block words for the multi-block GHASH accumulator.
module ghash_input_framer
  import ghash_pkg::*;
#(
  parameter int unsigned N_BLOCKS      = 2,
  parameter int unsigned LOG2_N_BLOCKS = 1,
  parameter int unsigned NB_DATA       = N_BLOCKS * NB_BLOCK,
  parameter int unsigned NB_LEN        = 64
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_start,
  input  logic [NB_LEN-1:0]   i_len_aad_bits,
  input  logic [NB_LEN-1:0]   i_len_ct_bits,
  input  logic [NB_DATA-1:0]  i_aad_bus,
  input  logic                i_aad_valid,
  output logic                o_aad_ready,
  input  logic [NB_DATA-1:0]  i_ct_bus,
  input  logic                i_ct_valid,
  output logic                o_ct_ready,
  output logic [NB_DATA-1:0]  o_data_x_bus,
  output logic                o_valid,
  output logic                o_sop,
  output logic [N_BLOCKS-1:0] o_skip_bus,
  output logic                o_last,
  output logic                o_idle,
  output logic                o_error
);

  localparam int unsigned NB_CNT = NB_LEN - 7;
  localparam logic [NB_CNT-1:0]        FullCnt = NB_CNT'(N_BLOCKS);
  localparam logic [LOG2_N_BLOCKS:0]   FullN   = (LOG2_N_BLOCKS + 1)'(N_BLOCKS);
  localparam logic [N_BLOCKS-1:0]      LenSkip = {{(N_BLOCKS - 1){1'b1}}, 1'b0};

  function automatic logic [NB_CNT-1:0] blocks_of(input logic [NB_LEN-1:0] len);
    return len[NB_LEN-1:7] + NB_CNT'(|len[6:0]);
  endfunction

  state_e              state_q;
  logic [NB_CNT-1:0]   blocks_left_q;
  logic [NB_LEN-1:0]   len_aad_q, len_ct_q;
  logic                sop_pend_q;

  logic                last_word, pad_en, word_valid, start_ok;
  logic [LOG2_N_BLOCKS:0] n_blocks;
  logic [NB_DATA-1:0]  phase_bus, masked_bus;
  logic [3:0]          phase_k;
  logic [N_BLOCKS-1:0] masked_skip;
  logic [NB_CNT-1:0]   start_aad_blocks, start_ct_blocks, held_ct_blocks;

  assign o_aad_ready = (state_q == StAad);
  assign o_ct_ready  = (state_q == StCt);

  // Word sizing and input selection for the current phase.
  always_comb begin
    last_word        = (blocks_left_q <= FullCnt);
    n_blocks         = last_word ? blocks_left_q[LOG2_N_BLOCKS:0] : FullN;
    phase_bus        = (state_q == StCt) ? i_ct_bus : i_aad_bus;
    phase_k          = (state_q == StCt) ? len_ct_q[6:3] : len_aad_q[6:3];
    pad_en           = last_word && (phase_k != 4'd0);
    word_valid       = ((state_q == StAad) && i_aad_valid) || ((state_q == StCt) && i_ct_valid);
    start_ok         = ~|i_len_aad_bits[2:0] & ~|i_len_ct_bits[2:0];
    start_aad_blocks = blocks_of(i_len_aad_bits);
    start_ct_blocks  = blocks_of(i_len_ct_bits);
    held_ct_blocks   = blocks_of(len_ct_q);
  end

  ghash_pad_mask #(
    .N_BLOCKS      (N_BLOCKS),
    .LOG2_N_BLOCKS (LOG2_N_BLOCKS),
    .NB_DATA       (NB_DATA)
  ) u_pad_mask (
    .i_data_bus   (phase_bus),
    .i_n_blocks   (n_blocks),
    .i_pad_en     (pad_en),
    .i_last_bytes (phase_k),
    .o_data_bus   (masked_bus),
    .o_skip_bus   (masked_skip)
  );

  // Message FSM with registered outputs.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q       <= StIdle;
      blocks_left_q <= '0;
      len_aad_q     <= '0;
      len_ct_q      <= '0;
      sop_pend_q    <= 1'b0;
      o_data_x_bus  <= '0;
      o_valid       <= 1'b0;
      o_sop         <= 1'b0;
      o_skip_bus    <= '0;
      o_last        <= 1'b0;
      o_idle        <= 1'b1;
      o_error       <= 1'b0;
    end else begin
      o_data_x_bus <= '0;
      o_valid      <= 1'b0;
      o_sop        <= 1'b0;
      o_skip_bus   <= '0;
      o_last       <= 1'b0;
      o_error      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            if (!start_ok) begin
              o_error <= 1'b1;
            end else begin
              len_aad_q  <= i_len_aad_bits;
              len_ct_q   <= i_len_ct_bits;
              sop_pend_q <= 1'b1;
              o_idle     <= 1'b0;
              if (start_aad_blocks != '0) begin
                state_q       <= StAad;
                blocks_left_q <= start_aad_blocks;
              end else if (start_ct_blocks != '0) begin
                state_q       <= StCt;
                blocks_left_q <= start_ct_blocks;
              end else begin
                state_q <= StLen;
              end
            end
          end
        end
        StAad, StCt: begin
          if (word_valid) begin
            o_data_x_bus  <= masked_bus;
            o_skip_bus    <= masked_skip;
            o_valid       <= 1'b1;
            o_sop         <= sop_pend_q;
            sop_pend_q    <= 1'b0;
            blocks_left_q <= blocks_left_q - NB_CNT'(n_blocks);
            if (last_word) begin
              if ((state_q == StAad) && (held_ct_blocks != '0)) begin
                state_q       <= StCt;
                blocks_left_q <= held_ct_blocks;
              end else begin
                state_q <= StLen;
              end
            end
          end
        end
        StLen: begin
          o_data_x_bus <= NB_DATA'(len_block(len_aad_q, len_ct_q));
          o_skip_bus   <= LenSkip;
          o_valid      <= 1'b1;
          o_last       <= 1'b1;
          o_sop        <= sop_pend_q;
          sop_pend_q   <= 1'b0;
          o_idle       <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_input_framer.sv
// Bench for ghash_input_framer: a message-level model predicts every output
// word and its cycle; one compare process checks the outputs every cycle.
module tb_ghash_input_framer;

  localparam int NB_DATA = 256;
  localparam int NB_LEN  = 64;

  logic               clk = 1'b0;
  logic               i_reset_n = 1'b0;
  logic               i_start = 1'b0;
  logic [NB_LEN-1:0]  i_len_aad_bits = '0, i_len_ct_bits = '0;
  logic [NB_DATA-1:0] i_aad_bus = '0, i_ct_bus = '0;
  logic               i_aad_valid = 1'b0, i_ct_valid = 1'b0;
  logic               o_aad_ready, o_ct_ready, o_valid, o_sop, o_last, o_idle, o_error;
  logic [NB_DATA-1:0] o_data_x_bus;
  logic [1:0]         o_skip_bus;

  always #5 clk = ~clk;

  ghash_input_framer dut (
    .i_clock        (clk),
    .i_reset_n      (i_reset_n),
    .i_start        (i_start),
    .i_len_aad_bits (i_len_aad_bits),
    .i_len_ct_bits  (i_len_ct_bits),
    .i_aad_bus      (i_aad_bus),
    .i_aad_valid    (i_aad_valid),
    .o_aad_ready    (o_aad_ready),
    .i_ct_bus       (i_ct_bus),
    .i_ct_valid     (i_ct_valid),
    .o_ct_ready     (o_ct_ready),
    .o_data_x_bus   (o_data_x_bus),
    .o_valid        (o_valid),
    .o_sop          (o_sop),
    .o_skip_bus     (o_skip_bus),
    .o_last         (o_last),
    .o_idle         (o_idle),
    .o_error        (o_error)
  );

  typedef struct {
    int                 cyc;
    logic [NB_DATA-1:0] data;
    logic [1:0]         skip;
    logic               sop;
    logic               last;
  } exp_t;

  exp_t               expq[$];
  exp_t               cmp_e;
  logic [NB_DATA-1:0] seen_data[$];
  logic [1:0]         seen_skip[$];
  logic               seen_sop[$], seen_last[$];
  int                 errors = 0, checks = 0, cyc = 0, err_cyc = -1;
  bit                 run_cmp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [NB_DATA-1:0] got,
                     input logic [NB_DATA-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Per-cycle compare against the predicted word stream.
  always @(negedge clk) begin
    if (run_cmp) begin
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        cmp_e = expq.pop_front();
        checks++; errors++;
        $display("FAIL missing_word: expected at cycle %0d, no output word", cmp_e.cyc);
      end
      checks++;
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        cmp_e = expq.pop_front();
        if (o_valid !== 1'b1 || o_data_x_bus !== cmp_e.data || o_skip_bus !== cmp_e.skip ||
            o_sop !== cmp_e.sop || o_last !== cmp_e.last) begin
          errors++;
          $display("FAIL word@%0d: got v=%b sop=%b last=%b skip=%b d=%h want sop=%b last=%b skip=%b d=%h",
                   cyc, o_valid, o_sop, o_last, o_skip_bus, o_data_x_bus,
                   cmp_e.sop, cmp_e.last, cmp_e.skip, cmp_e.data);
        end
      end else if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL spurious_valid@%0d: got o_valid=%b want 0", cyc, o_valid);
      end
      checks++;
      if (o_error !== (cyc == err_cyc)) begin
        errors++;
        $display("FAIL error_pulse@%0d: got %b want %b", cyc, o_error, cyc == err_cyc);
      end
      if (o_valid === 1'b1) begin
        seen_data.push_back(o_data_x_bus);
        seen_skip.push_back(o_skip_bus);
        seen_sop.push_back(o_sop);
        seen_last.push_back(o_last);
      end
    end
  end

  function automatic int nblocks(input longint unsigned len);
    return int'(len / 128) + (((len % 128) != 0) ? 1 : 0);
  endfunction

  // Expected word: n live blocks; if this word ends the phase and the final
  // block holds k<16 bytes, only bytes 0..k-1 (from the MSB end) survive.
  function automatic logic [NB_DATA-1:0] expect_word(input logic [NB_DATA-1:0] din, input int n,
                                                     input bit ends_phase, input int k,
                                                     output logic [1:0] skip);
    logic [NB_DATA-1:0] q;
    int                 off;
    q = '0;
    skip = 2'b00;
    for (int b = 0; b < 2; b++) begin
      if (b >= n) begin
        skip[b] = 1'b1;
      end else begin
        for (int j = 0; j < 16; j++) begin
          off = b * 128 + 127 - 8 * j;
          if (!(ends_phase && b == n - 1 && k != 0 && j >= k)) q[off -: 8] = din[off -: 8];
        end
      end
    end
    return q;
  endfunction

  function automatic logic [NB_DATA-1:0] rnd_word();
    logic [NB_DATA-1:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic step(input string name, input logic aad_rdy, input logic ct_rdy);
    @(negedge clk);
    chk({name, "_aad_ready"}, o_aad_ready, aad_rdy);
    chk({name, "_ct_ready"}, o_ct_ready, ct_rdy);
    @(posedge clk); #1;
  endtask

  // Drive a whole message and push its predicted output words.
  task automatic run_msg(input longint unsigned la, input longint unsigned lc, input int ct_gap,
                         input bit poke_start, input int abort_after, input bit ones);
    int na, nc, left, n, idx, last_drive;
    bit sop_p, ends;
    logic [NB_DATA-1:0] w;
    logic [1:0] sk;
    exp_t e;
    na = nblocks(la);
    nc = nblocks(lc);
    i_start = 1'b1; i_len_aad_bits = la; i_len_ct_bits = lc;
    last_drive = cyc;
    @(negedge clk); chk("idle_at_start", o_idle, 1'b1);
    @(posedge clk); #1;
    i_start = 1'b0;
    sop_p = 1'b1;
    left = na;
    while (left > 0) begin
      n = (left < 2) ? left : 2;
      ends = (left <= 2);
      w = ones ? '1 : rnd_word();
      i_aad_bus = w; i_aad_valid = 1'b1;
      e.data = expect_word(w, n, ends, int'((la % 128) / 8), sk);
      e.skip = sk; e.sop = sop_p; e.last = 1'b0; e.cyc = cyc + 1;
      expq.push_back(e);
      sop_p = 1'b0; left -= n; last_drive = cyc;
      step("aad", 1'b1, 1'b0);
    end
    i_aad_valid = 1'b0;
    left = nc; idx = 0;
    while (left > 0) begin
      if (idx > 0) begin
        for (int g = 0; g < ct_gap; g++) begin
          i_ct_valid = 1'b0;
          i_start = poke_start; i_len_aad_bits = 64'd100; i_len_ct_bits = 64'd8;
          step("ct_gap", 1'b0, 1'b1);
          i_start = 1'b0;
        end
      end
      n = (left < 2) ? left : 2;
      ends = (left <= 2);
      w = rnd_word();
      i_ct_bus = w; i_ct_valid = 1'b1;
      e.data = expect_word(w, n, ends, int'((lc % 128) / 8), sk);
      e.skip = sk; e.sop = sop_p; e.last = 1'b0; e.cyc = cyc + 1;
      expq.push_back(e);
      sop_p = 1'b0; left -= n; last_drive = cyc; idx++;
      step("ct", 1'b0, 1'b1);
      if (idx == abort_after) begin
        i_ct_valid = 1'b0; i_reset_n = 1'b0;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
        chk("reset_idle", o_idle, 1'b1);
        chk("reset_valid", o_valid, 1'b0);
        chk("reset_ct_ready", o_ct_ready, 1'b0);
        i_reset_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
    end
    i_ct_valid = 1'b0;
    e.data = {128'd0, la[63:0], lc[63:0]};
    e.skip = 2'b10; e.sop = sop_p; e.last = 1'b1; e.cyc = last_drive + 2;
    expq.push_back(e);
    @(negedge clk);
    chk("len_not_idle", o_idle, 1'b0);
    chk("len_aad_ready", o_aad_ready, 1'b0);
    chk("len_ct_ready", o_ct_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); chk("idle_after_len", o_idle, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic clear_seen();
    seen_data.delete(); seen_skip.delete(); seen_sop.delete(); seen_last.delete();
  endtask

  initial begin
    logic [NB_DATA-1:0] w1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_idle", o_idle, 1'b1);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_outs", {o_sop, o_last, o_error, o_skip_bus, o_aad_ready, o_ct_ready}, '0);
    chk("rst_data", o_data_x_bus, '0);
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    run_cmp = 1'b1;
    @(posedge clk); #1;

    // 1: AAD 160 bits (all-ones data), CT 256 bits.
    clear_seen();
    run_msg(160, 256, 0, 1'b0, -1, 1'b1);
    chk("t1_count", seen_data.size(), 3);
    w1 = {32'hFFFF_FFFF, 96'd0, {128{1'b1}}};
    if (seen_data.size() == 3) begin
      chk("t1_aad_data", seen_data[0], w1);
      chk("t1_aad_sop_skip", {seen_sop[0], seen_skip[0]}, 3'b100);
      chk("t1_ct_sop_skip", {seen_sop[1], seen_skip[1]}, 3'b000);
      chk("t1_len_block", seen_data[2], {128'd0, 64'd160, 64'd256});
      chk("t1_len_flags", {seen_last[2], seen_skip[2]}, 3'b110);
    end

    // 2: CT only, 3 blocks.
    clear_seen();
    run_msg(0, 384, 0, 1'b0, -1, 1'b0);
    chk("t2_count", seen_data.size(), 3);
    if (seen_data.size() == 3) begin
      chk("t2_w1_sop_skip", {seen_sop[0], seen_skip[0]}, 3'b100);
      chk("t2_w2_skip", seen_skip[1], 2'b10);
      chk("t2_w2_blk1", seen_data[1][255:128], '0);
    end

    // 3: both lengths zero.
    clear_seen();
    run_msg(0, 0, 0, 1'b0, -1, 1'b0);
    chk("t3_count", seen_data.size(), 1);
    if (seen_data.size() == 1)
      chk("t3_len_word", {seen_sop[0], seen_last[0], seen_skip[0], seen_data[0]},
          {4'b1110, 256'd0});

    // 4: non-byte AAD length is rejected.
    clear_seen();
    i_start = 1'b1; i_len_aad_bits = 64'd100; i_len_ct_bits = 64'd0;
    err_cyc = cyc + 1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk); chk("t4_idle", o_idle, 1'b1); chk("t4_error", o_error, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); chk("t4_idle2", o_idle, 1'b1); chk("t4_error_gone", o_error, 1'b0);
    repeat (2) @(posedge clk); #1;
    chk("t4_no_valid", seen_data.size(), 0);

    // 5: reset mid-message, then a fresh message starts with sop.
    clear_seen();
    run_msg(0, 512, 0, 1'b0, 1, 1'b0);
    chk("t5_words_before_reset", seen_data.size(), 1);
    clear_seen();
    run_msg(128, 0, 0, 1'b0, -1, 1'b0);
    chk("t5_count", seen_data.size(), 2);
    if (seen_data.size() == 2) chk("t5_sop", seen_sop[0], 1'b1);

    // 6: CT valid 1,0,0,1 with a start pulsed during the gap.
    clear_seen();
    run_msg(0, 512, 2, 1'b1, -1, 1'b0);
    chk("t6_count", seen_data.size(), 3);

    // Odd-length padding in both phases.
    clear_seen();
    run_msg(296, 72, 1, 1'b0, -1, 1'b0);
    chk("t7_count", seen_data.size(), 4);

    repeat (3) @(posedge clk); #1;
    chk("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
